trigger_crossbar: RTL and testbench
===================================

TRIGGER_CROSSBAR -- requirements
Module: trigger_crossbar

Interface
REQ-001 SHALL have parameter NUM_IN, default 12, number of trigger inputs.
REQ-002 SHALL have parameter NUM_OUT, default 12, number of trigger outputs.
REQ-003 SHALL have parameter STRETCH_BITS, default 16, width of the per-output pulse-stretch length.
REQ-004 Port list:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- trig_in  input  NUM_IN  asynchronous trigger inputs.
- trig_out  output  NUM_OUT  registered trigger outputs.
- cfg_wr_en  input  1  config write strobe.
- cfg_addr  input  clog2(NUM_OUT)  output channel being configured.
- cfg_sel  input  clog2(NUM_IN)  source input index.
- cfg_mode  input  2  00 level, 01 rising-edge pulse, 10 falling-edge pulse, 11 disabled.
- cfg_invert  input  1  invert the final output.
- cfg_stretch  input  STRETCH_BITS  pulse length minus one.
- cnt_rd_addr  input  clog2(NUM_OUT)  event counter read index.
- cnt_rd_clear  input  1  clear the addressed counter on read.
- cnt_rd_data  output  32  event counter read data.

Function
REQ-005 Each trig_in bit SHALL pass through a 2-flop synchronizer; all further logic SHALL use the synchronized value s[i].
REQ-006 In level mode, trig_out[o] SHALL equal s[sel[o]] XOR invert[o], registered once: a trig_in change at cycle N SHALL appear at trig_out at cycle N+3.
REQ-007 In edge modes, a qualifying edge on s[sel[o]] SHALL load counter[o] with stretch[o] and assert the pulse at N+3. The pulse SHALL last exactly stretch[o]+1 cycles.
REQ-008 An edge detected while a pulse is active SHALL reload the counter (retrigger), extending the pulse; the pulse SHALL NOT gap.
REQ-009 In disabled mode, the pre-invert value SHALL be 0, so trig_out equals invert[o].
REQ-010 A cfg_sel value of NUM_IN or greater SHALL force the pre-invert value to 0.
REQ-011 When cfg_wr_en is asserted, the config for cfg_addr SHALL update at that clock edge and take effect on trig_out at the next cycle. A write SHALL clear that channel's stretch counter and edge history.
REQ-012 A cfg_addr of NUM_OUT or greater SHALL be ignored.
REQ-013 Writes SHALL always be accepted; there is no backpressure.
REQ-014 Edge detection SHALL be masked for the first 3 cycles after rst deasserts, so an input held high through reset produces no pulse.

Reset
REQ-015 While rst is high, trig_out and all synchronizer, edge-history and stretch-counter flops SHALL be 0.
REQ-016 Reset SHALL set the config of output o to: sel = o mod NUM_IN, mode 00, invert 0, stretch 0. This gives identity 1:1 forwarding.
REQ-017 Reset SHALL set cnt_rd_data to 0, and all counters to 0 when they are compiled in.

Configuration
REQ-018 Macro TRIGGER_CROSSBAR_COUNTERS_EN, when defined, SHALL compile in per-output 32-bit event counters:
- Each counter increments on every rising edge of its pre-invert output value.
- Each counter saturates at 0xFFFFFFFF.
- cnt_rd_data SHALL return the counter selected by cnt_rd_addr with 1-cycle latency.
- When cnt_rd_clear is high, the counter is zeroed in the same cycle it is sampled. An increment in that cycle is lost.
REQ-019 When TRIGGER_CROSSBAR_COUNTERS_EN is undefined, the ports SHALL remain, cnt_rd_data SHALL be constant 0, and no counter logic SHALL be synthesised.

Verification
REQ-020 Reset, then toggle trig_in[5] at cycle N -> trig_out[5] follows at N+3, and all other outputs follow their matching inputs.
REQ-021 Write addr 2 with sel 7, mode 01, stretch 4; give trig_in[7] a 1-cycle rising edge -> trig_out[2] high for exactly 5 cycles.
REQ-022 Same config as REQ-021, with a second rising edge 3 cycles into the pulse -> trig_out[2] continuously high for 3+5=8 cycles.
REQ-023 Hold trig_in[0] high through reset, with output 0 in mode 01 -> no pulse; output 0 in mode 10 with invert 1 -> trig_out[0]=1 idle, 0 during pulses.
REQ-024 Write addr NUM_OUT, and separately set sel NUM_IN on addr 3 -> no config change for the out-of-range address; trig_out[3]=invert[3].
REQ-025 With counters enabled, give 3 rising edges on output 1, then read with clear -> cnt_rd_data=3; next read returns 0. With counters disabled -> 0 always.

Source files
------------

// File: rtl/trigger_crossbar.sv
// Trigger crossbar: synchronized inputs routed to registered outputs in level or edge-pulse mode.
// Define TRIGGER_CROSSBAR_COUNTERS_EN to compile in per-output 32-bit event counters.

module trigger_crossbar_lane #(
  parameter int NUM_IN       = 12,
  parameter int STRETCH_BITS = 16,
  parameter int SEL_W        = 4,
  parameter int RST_SEL      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       i_s,
  input  logic                    i_edge_en,
  input  logic                    i_wr,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [1:0]              i_mode,
  input  logic                    i_invert,
  input  logic [STRETCH_BITS-1:0] i_stretch,
  output logic                    o_out,
  output logic                    o_rise
);
  localparam logic [SEL_W:0]   NIN  = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] RSEL = SEL_W'(RST_SEL);

  logic [SEL_W-1:0]        r_sel;
  logic [1:0]              r_mode;
  logic                    r_inv;
  logic [STRETCH_BITS-1:0] r_stretch;
  logic [STRETCH_BITS-1:0] r_cnt;
  logic                    r_pre;
  logic                    r_hist;
  logic                    r_hval;
  logic                    r_out;

  logic                    w_src;
  logic                    w_edge;
  logic                    w_pre_n;
  logic [STRETCH_BITS-1:0] w_cnt_n;

  always_comb begin
    w_src = 1'b0;
    if ({1'b0, r_sel} < NIN) w_src = i_s[r_sel];

    // r_hval gates edges until the history holds a sample taken under the current config
    w_edge = 1'b0;
    case (r_mode)
      2'b01:   w_edge = w_src & ~r_hist;
      2'b10:   w_edge = ~w_src & r_hist;
      default: w_edge = 1'b0;
    endcase
    w_edge = w_edge & i_edge_en & r_hval;

    w_pre_n = 1'b0;
    w_cnt_n = '0;
    case (r_mode)
      2'b00: w_pre_n = w_src;
      2'b01, 2'b10: begin
        if (w_edge) begin
          w_pre_n = 1'b1;
          w_cnt_n = r_stretch;
        end else if (r_pre && r_cnt != '0) begin
          w_pre_n = 1'b1;
          w_cnt_n = r_cnt - STRETCH_BITS'(1);
        end
      end
      default: w_pre_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= RSEL;
      r_mode    <= 2'b00;
      r_inv     <= 1'b0;
      r_stretch <= '0;
      r_cnt     <= '0;
      r_pre     <= 1'b0;
      r_hist    <= 1'b0;
      r_hval    <= 1'b0;
      r_out     <= 1'b0;
    end else begin
      r_out <= w_pre_n ^ r_inv;
      r_pre <= w_pre_n;
      if (i_wr) begin
        r_sel     <= i_sel;
        r_mode    <= i_mode;
        r_inv     <= i_invert;
        r_stretch <= i_stretch;
        r_cnt     <= '0;
        r_hist    <= 1'b0;
        r_hval    <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_n;
        r_hist <= w_src;
        r_hval <= 1'b1;
      end
    end
  end

  assign o_out  = r_out;
  assign o_rise = w_pre_n & ~r_pre;
endmodule

module trigger_crossbar #(
  parameter  int NUM_IN       = 12,
  parameter  int NUM_OUT      = 12,
  parameter  int STRETCH_BITS = 16,
  localparam int SW           = $clog2(NUM_IN),
  localparam int AW           = $clog2(NUM_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       trig_in,
  output logic [NUM_OUT-1:0]      trig_out,
  input  logic                    cfg_wr_en,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [SW-1:0]           cfg_sel,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_invert,
  input  logic [STRETCH_BITS-1:0] cfg_stretch,
  input  logic [AW-1:0]           cnt_rd_addr,
  input  logic                    cnt_rd_clear,
  output logic [31:0]             cnt_rd_data
);
  logic [NUM_IN-1:0]  r_sync1;
  logic [NUM_IN-1:0]  r_sync2;
  logic [1:0]         r_mask;
  logic               w_edge_en;
  logic [NUM_OUT-1:0] w_wr;
  logic [NUM_OUT-1:0] w_rise;

  // The mask hides the 0->1 step the synchronizer shows for inputs held high through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_mask  <= 2'd0;
    end else begin
      r_sync1 <= trig_in;
      r_sync2 <= r_sync1;
      if (r_mask != 2'd3) r_mask <= r_mask + 2'd1;
    end
  end

  assign w_edge_en = (r_mask == 2'd3);

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_lane
    assign w_wr[o] = cfg_wr_en && (cfg_addr == AW'(o));
    trigger_crossbar_lane #(
      .NUM_IN(NUM_IN), .STRETCH_BITS(STRETCH_BITS), .SEL_W(SW), .RST_SEL(o % NUM_IN)
    ) u_lane (
      .clk(clk), .rst(rst), .i_s(r_sync2), .i_edge_en(w_edge_en), .i_wr(w_wr[o]),
      .i_sel(cfg_sel), .i_mode(cfg_mode), .i_invert(cfg_invert), .i_stretch(cfg_stretch),
      .o_out(trig_out[o]), .o_rise(w_rise[o])
    );
  end

`ifdef TRIGGER_CROSSBAR_COUNTERS_EN
  localparam logic [AW:0] NOUT = (AW+1)'(NUM_OUT);

  logic [NUM_OUT-1:0][31:0] r_evt;
  logic [31:0]              r_rd_data;

  // Read-with-clear returns the pre-clear value; a rise in the clearing cycle is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt     <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_data <= ({1'b0, cnt_rd_addr} < NOUT) ? r_evt[cnt_rd_addr] : 32'd0;
      for (int o = 0; o < NUM_OUT; o++) begin
        if (cnt_rd_clear && cnt_rd_addr == AW'(o)) r_evt[o] <= '0;
        else if (w_rise[o] && r_evt[o] != 32'hFFFF_FFFF) r_evt[o] <= r_evt[o] + 32'd1;
      end
    end
  end

  assign cnt_rd_data = r_rd_data;
`else
  logic w_unused;
  assign w_unused    = ^{cnt_rd_addr, cnt_rd_clear, w_rise};
  assign cnt_rd_data = 32'd0;
`endif
endmodule

// File: tb/tb_trigger_crossbar.sv
// Scoreboarded random/directed bench for trigger_crossbar against a cycle-indexed reference model.
module tb_trigger_crossbar;
  localparam int NI = 12, NO = 12, SB = 16, AW = 4, SW = 4, MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] trig_in;
  logic [NO-1:0] trig_out;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_sel;
  logic [1:0]    cfg_mode;
  logic          cfg_invert;
  logic [SB-1:0] cfg_stretch;
  logic [AW-1:0] cnt_rd_addr;
  logic          cnt_rd_clear;
  logic [31:0]   cnt_rd_data;

  always #5 clk = ~clk;

  trigger_crossbar #(.NUM_IN(NI), .NUM_OUT(NO), .STRETCH_BITS(SB)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .trig_out(trig_out),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
    .cfg_invert(cfg_invert), .cfg_stretch(cfg_stretch),
    .cnt_rd_addr(cnt_rd_addr), .cnt_rd_clear(cnt_rd_clear), .cnt_rd_data(cnt_rd_data)
  );

  typedef struct {
    int          cyc;
    logic [NO-1:0] out;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];

  // Stimulus log, indexed by the cycle it was driven in (sampled at the following edge)
  logic          l_rst [MAXC];
  logic [NI-1:0] l_in  [MAXC];
  logic          l_wr  [MAXC];
  logic [AW-1:0] l_addr[MAXC];
  logic [SW-1:0] l_sel [MAXC];
  logic [1:0]    l_mode[MAXC];
  logic          l_inv [MAXC];
  logic [SB-1:0] l_st  [MAXC];
  logic [AW-1:0] l_rda [MAXC];
  logic          l_clr [MAXC];

  int     m_sel[NO], m_mode[NO], m_st[NO], m_apply[NO], m_until[NO];
  logic   m_inv[NO], m_pre[NO];
  longint m_cnt[NO];
  int     m_R;

  logic          d_rst, d_wr, d_inv, d_clr;
  logic [NI-1:0] d_in;
  logic [AW-1:0] d_addr, d_rda;
  logic [SW-1:0] d_sel;
  logic [1:0]    d_mode;
  logic [SB-1:0] d_st;

  int k;
  int n_checks = 0, n_err = 0;

  // Expected outputs seen just after edge c: input driven in cycle j reaches trig_out after edge j+3
  task automatic model_cycle(input int c, output logic [NO-1:0] eo, output logic [31:0] er);
    logic src, srcp, pre, edge_ok;
    int   a;
    eo = '0;
    er = '0;
    if (l_rst[c-1]) begin
      for (int o = 0; o < NO; o++) begin
        m_sel[o] = o % NI; m_mode[o] = 0; m_inv[o] = 1'b0; m_st[o] = 0;
        m_apply[o] = -100; m_until[o] = -100; m_pre[o] = 1'b0; m_cnt[o] = 0;
      end
      m_R = c;
      return;
    end
    if (!l_rst[c-2] && l_wr[c-2] && int'(l_addr[c-2]) < NO) begin
      a = int'(l_addr[c-2]);
      m_sel[a] = int'(l_sel[c-2]); m_mode[a] = int'(l_mode[c-2]);
      m_inv[a] = l_inv[c-2]; m_st[a] = int'(l_st[c-2]);
      m_apply[a] = c; m_until[a] = -100;
    end
`ifdef TRIGGER_CROSSBAR_COUNTERS_EN
    if (int'(l_rda[c-1]) < NO) er = 32'(m_cnt[int'(l_rda[c-1])]);
`endif
    for (int o = 0; o < NO; o++) begin
      src = 1'b0;
      srcp = 1'b0;
      if (m_sel[o] < NI) begin
        if (c - 3 >= m_R) src  = l_in[c-3][m_sel[o]];
        if (c - 4 >= m_R) srcp = l_in[c-4][m_sel[o]];
      end
      edge_ok = (c >= m_R + 4) && (c >= m_apply[o] + 1);
      case (m_mode[o])
        0: pre = src;
        1: begin
          if (edge_ok && src && !srcp) m_until[o] = c + m_st[o];
          pre = (c <= m_until[o]);
        end
        2: begin
          if (edge_ok && !src && srcp) m_until[o] = c + m_st[o];
          pre = (c <= m_until[o]);
        end
        default: pre = 1'b0;
      endcase
      eo[o] = pre ^ m_inv[o];
      if (l_clr[c-1] && int'(l_rda[c-1]) == o) m_cnt[o] = 0;
      else if (pre && !m_pre[o] && m_cnt[o] < 64'hFFFF_FFFF) m_cnt[o] = m_cnt[o] + 1;
      m_pre[o] = pre;
    end
  endtask

  task automatic drive_log();
    rst = d_rst; trig_in = d_in; cfg_wr_en = d_wr; cfg_addr = d_addr; cfg_sel = d_sel;
    cfg_mode = d_mode; cfg_invert = d_inv; cfg_stretch = d_st;
    cnt_rd_addr = d_rda; cnt_rd_clear = d_clr;
    l_rst[k] = d_rst; l_in[k] = d_in; l_wr[k] = d_wr; l_addr[k] = d_addr; l_sel[k] = d_sel;
    l_mode[k] = d_mode; l_inv[k] = d_inv; l_st[k] = d_st; l_rda[k] = d_rda; l_clr[k] = d_clr;
  endtask

  task automatic step();
    logic [NO-1:0] eo;
    logic [31:0]   er;
    @(posedge clk);
    #1;
    if (k >= MAXC) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", k, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_cycle(k, eo, er);
    sbq.push_back('{k, eo, er});
    drive_log();
    d_wr = 1'b0;
    d_clr = 1'b0;
    k++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic cfg_write(input int addr, input int sel, input int mode, input logic inv, input int st);
    d_wr = 1'b1; d_addr = AW'(addr); d_sel = SW'(sel); d_mode = 2'(mode); d_inv = inv; d_st = SB'(st);
    step();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (trig_out !== e.out) begin
          n_err++;
          $display("FAIL trig_out cyc %0d: got %h expected %h", e.cyc, trig_out, e.out);
        end
        n_checks++;
        if (cnt_rd_data !== e.rd) begin
          n_err++;
          $display("FAIL cnt_rd_data cyc %0d: got %0d expected %0d", e.cyc, cnt_rd_data, e.rd);
        end
      end
    end
  end

  initial begin
    k = 0;
    d_rst = 1'b1; d_in = '1; d_wr = 1'b0; d_addr = '0; d_sel = '0; d_mode = 2'b00;
    d_inv = 1'b0; d_st = '0; d_rda = '0; d_clr = 1'b0;
    drive_log();
    k = 1;
    steps(3);

    // Inputs held high through reset; edge modes configured on the first free cycle
    d_rst = 1'b0;
    cfg_write(0, 0, 1, 1'b0, 2);
    steps(8);
    cfg_write(0, 0, 2, 1'b1, 3);
    steps(5);
    d_in[0] = 1'b0; step();
    d_in[0] = 1'b1; steps(8);
    cfg_write(0, 0, 0, 1'b0, 0);

    d_in = NI'($urandom);
    steps(4);
    for (int i = 0; i < 4; i++) begin
      d_in[5] = ~d_in[5];
      steps(i + 1);
    end
    steps(4);

    cfg_write(2, 7, 1, 1'b0, 4);
    d_in[7] = 1'b0; steps(5);
    d_in[7] = 1'b1; step();
    d_in[7] = 1'b0; steps(10);
    d_in[7] = 1'b1; step();
    d_in[7] = 1'b0; steps(2);
    d_in[7] = 1'b1; step();
    d_in[7] = 1'b0; steps(12);

    cfg_write(NO, 0, 3, 1'b1, 5);
    cfg_write(3, NI, 0, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      d_in = NI'($urandom);
      step();
    end

    cfg_write(1, 1, 0, 1'b0, 0);
    d_in[1] = 1'b0; steps(4);
    d_rda = AW'(1); d_clr = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      d_in[1] = 1'b1; steps(2);
      d_in[1] = 1'b0; steps(2);
    end
    steps(4);
    d_clr = 1'b1; step();
    step();
    steps(2);

    repeat (1500) begin
      for (int i = 0; i < NI; i++) if ($urandom_range(0, 7) == 0) d_in[i] = ~d_in[i];
      if ($urandom_range(0, 9) == 0) begin
        d_wr = 1'b1; d_addr = AW'($urandom_range(0, 15)); d_sel = SW'($urandom_range(0, 15));
        d_mode = 2'($urandom_range(0, 3)); d_inv = 1'($urandom_range(0, 1));
        d_st = SB'($urandom_range(0, 6));
      end
      d_rda = AW'($urandom_range(0, 15));
      d_clr = ($urandom_range(0, 7) == 0);
      d_rst = ($urandom_range(0, 399) == 0);
      step();
    end
    d_rst = 1'b0;
    steps(6);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
